// File: rtl/serial_paralelo_param.sv
// Purpose : serial-to-parallel deserializer on the bit clock; finds COM at any bit offset,
//           locks after LOCK_COUNT aligned COMs, then presents each received word.
// Latency : data_out/valid_out update on the edge that samples the last bit of a word.
// Backpressure: none; the serial stream cannot be stalled, and words are overwritten every WIDTH cycles.
// Optional feature: define SP_REALIGN_EN to leave ACTIVE after MISALIGN_LIMIT off-boundary COMs.
// Ports:
//   clk_32f     in   bit clock, all state changes on its rising edge
//   reset       in   asynchronous active-low reset
//   data_in     in   serial bit, MSB of each symbol first
//   data_out    out  [WIDTH-1:0] last word captured in ACTIVE (COM_SYMBOL otherwise)
//   valid_out   out  data_out is a non-COM word received in ACTIVE
//   word_strobe out  one-cycle pulse after each word boundary in ALIGN/ACTIVE
//   active      out  high while in ACTIVE
module serial_paralelo_param #(
  parameter int unsigned      WIDTH          = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL     = WIDTH'(8'hBC),
  parameter int unsigned      LOCK_COUNT     = 2,
  parameter int unsigned      MISALIGN_LIMIT = 2
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_strobe,
  output logic             active
);

  localparam int unsigned CNT_W  = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam int unsigned LOCK_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  // Only WIDTH-1 history bits are stored; the newest bit comes straight from data_in.
  logic [WIDTH-2:0]    sr_q, sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LOCK_W-1:0]   com_cnt_q, com_cnt_d;
  logic [LOCK_W-1:0]   com_inc;
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic                valid_q, valid_d;
  logic                strobe_q, strobe_d;
  logic                active_q, active_d;

  logic [WIDTH-1:0]    sr_next;
  logic                is_com;
  logic                boundary;

`ifdef SP_REALIGN_EN
  localparam int unsigned MIS_W = (MISALIGN_LIMIT < 2) ? 1 : $clog2(MISALIGN_LIMIT + 1);
  logic [MIS_W-1:0]    mis_cnt_q, mis_cnt_d;
  logic [MIS_W-1:0]    mis_inc;
`endif

  always_comb begin
    sr_next    = {sr_q, data_in};
    is_com     = (sr_next == COM_SYMBOL);
    boundary   = (bit_cnt_q == LAST_BIT);
    com_inc    = com_cnt_q + LOCK_W'(1);

    state_d    = state_q;
    sr_d       = sr_next[WIDTH-2:0];
    bit_cnt_d  = boundary ? '0 : bit_cnt_q + CNT_W'(1);
    com_cnt_d  = com_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    // Strobe reflects the state the boundary was seen in, so the failing
    // boundary of an ALIGN attempt still pulses.
    strobe_d   = boundary && (state_q != ST_SEARCH);
`ifdef SP_REALIGN_EN
    mis_cnt_d  = mis_cnt_q;
    mis_inc    = mis_cnt_q + MIS_W'(1);
`endif

    unique case (state_q)
      ST_SEARCH: begin
        if (is_com) begin
          // The matching bit closes a word, so the next word starts here.
          bit_cnt_d = '0;
          com_cnt_d = LOCK_W'(1);
          state_d   = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == LOCK_W'(LOCK_COUNT)) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
      end

      ST_ACTIVE: begin
        if (boundary) begin
          data_out_d = sr_next;
          valid_d    = !is_com;
        end
`ifdef SP_REALIGN_EN
        if (boundary) begin
          if (is_com) begin
            mis_cnt_d = '0;
          end
        end else if (is_com) begin
          if (mis_inc == MIS_W'(MISALIGN_LIMIT)) begin
            state_d    = ST_SEARCH;
            bit_cnt_d  = '0;
            mis_cnt_d  = '0;
            com_cnt_d  = '0;
            data_out_d = COM_SYMBOL;
            valid_d    = 1'b0;
          end else begin
            mis_cnt_d = mis_inc;
          end
        end
`endif
      end

      default: begin
        state_d    = ST_SEARCH;
        com_cnt_d  = '0;
        data_out_d = COM_SYMBOL;
        valid_d    = 1'b0;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      data_out_q <= COM_SYMBOL;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
    end
  end

`ifdef SP_REALIGN_EN
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      mis_cnt_q <= '0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
    end
  end
`endif

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign word_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_param.sv
module tb_serial_paralelo_param;

  localparam int W     = 8;
  localparam int COM   = 'hBC;
  localparam int LOCK  = 2;
  localparam int MISL  = 2;
  localparam int MASK  = (1 << W) - 1;

  localparam int M_SEARCH = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_ACTIVE = 2;

  logic         clk_32f;
  logic         reset;
  logic         data_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         word_strobe;
  logic         active;

  int n_cmp;
  int n_err;

  // Reference model: a sliding window of the last W bits, a count of bits
  // received into the current word, and the lock progress.
  int m_win, m_pos, m_mode, m_coms, m_mis;
  int exp_dat;
  bit exp_vld, exp_strb, exp_act;

  serial_paralelo_param #(
    .WIDTH(W), .COM_SYMBOL(W'(COM)), .LOCK_COUNT(LOCK), .MISALIGN_LIMIT(MISL)
  ) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .word_strobe(word_strobe), .active(active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic model_reset();
    m_win = 0; m_pos = 0; m_mode = M_SEARCH; m_coms = 0; m_mis = 0;
    exp_dat = COM; exp_vld = 0; exp_strb = 0; exp_act = 0;
  endtask

  task automatic model_step(input bit b);
    bit hit, bnd;
    m_win = ((m_win << 1) | int'(b)) & MASK;
    hit   = (m_win == COM);
    m_pos = m_pos + 1;
    bnd   = (m_pos == W);
    if (bnd) m_pos = 0;
    exp_strb = bnd && (m_mode != M_SEARCH);
    if (m_mode == M_SEARCH) begin
      if (hit) begin
        m_pos  = 0;
        m_coms = 1;
        m_mode = (LOCK == 1) ? M_ACTIVE : M_ALIGN;
      end
    end else if (m_mode == M_ALIGN) begin
      if (bnd) begin
        if (hit) begin
          m_coms = m_coms + 1;
          if (m_coms == LOCK) m_mode = M_ACTIVE;
        end else begin
          m_coms = 0;
          m_mode = M_SEARCH;
        end
      end
    end else begin
      if (bnd) begin
        exp_dat = m_win;
        exp_vld = !hit;
      end
`ifdef SP_REALIGN_EN
      if (bnd && hit) m_mis = 0;
      else if (!bnd && hit) begin
        m_mis = m_mis + 1;
        if (m_mis == MISL) begin
          m_mode = M_SEARCH; m_pos = 0; m_mis = 0; m_coms = 0;
          exp_dat = COM; exp_vld = 0;
        end
      end
`endif
    end
    exp_act = (m_mode == M_ACTIVE);
  endtask

  // Drive one bit, advance the model with the edge, sample 1 time unit later.
  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk_32f);
    model_step(b);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int j = W - 1; j >= 0; j--) send_bit(w[j]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    send_word(8'hBC); send_word(8'hBC); send_word(8'h5A);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'h5A) begin n_err++;
      $display("FAIL rst_pre_word: data_out=%h valid_out=%b expected 5a/1", data_out, valid_out); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (data_out !== 8'hBC) begin n_err++;
      $display("FAIL rst_async_data: data_out=%h expected bc", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++;
      $display("FAIL rst_async_valid: valid_out=%b expected 0", valid_out); end
    n_cmp++; if (active !== 1'b0) begin n_err++;
      $display("FAIL rst_async_active: active=%b expected 0", active); end
    n_cmp++; if (word_strobe !== 1'b0) begin n_err++;
      $display("FAIL rst_async_strobe: word_strobe=%b expected 0", word_strobe); end
    repeat (3) @(posedge clk_32f);
    #1;
    n_cmp++; if (active !== 1'b0 || data_out !== 8'hBC) begin n_err++;
      $display("FAIL rst_hold: active=%b data_out=%h expected 0/bc", active, data_out); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(i[0] ? 1'b0 : 1'b1);
      n_cmp++; if (valid_out !== 1'b0 || active !== 1'b0) begin n_err++;
        $display("FAIL rst_partial_discard bit %0d: valid_out=%b active=%b expected 0/0", i, valid_out, active); end
    end
  endtask

  task automatic test_lock_basic();
    logic [23:0] s;
    int strobes;
    s = {8'hBC, 8'hBC, 8'h5A};
    strobes = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      send_bit(s[23 - i]);
      if (word_strobe === 1'b1) strobes++;
      if (i == 14) begin
        n_cmp++; if (active !== 1'b0) begin n_err++;
          $display("FAIL lock_active_edge15: active=%b expected 0", active); end
      end
      if (i == 15) begin
        n_cmp++; if (active !== 1'b1) begin n_err++;
          $display("FAIL lock_active_edge16: active=%b expected 1", active); end
      end
      if (i == 22) begin
        n_cmp++; if (valid_out !== 1'b0) begin n_err++;
          $display("FAIL lock_valid_edge23: valid_out=%b expected 0", valid_out); end
      end
      if (i == 23) begin
        n_cmp++; if (data_out !== 8'h5A || valid_out !== 1'b1) begin n_err++;
          $display("FAIL lock_word_edge24: data_out=%h valid_out=%b expected 5a/1", data_out, valid_out); end
      end
    end
    n_cmp++; if (strobes != 2) begin n_err++;
      $display("FAIL lock_strobe_count: got %0d pulses expected 2", strobes); end
  endtask

  task automatic test_offset_lock();
    logic [26:0] s;
    s = {3'b101, 8'hBC, 8'hBC, 8'h3C};
    do_reset();
    for (int i = 0; i < 27; i++) begin
      send_bit(s[26 - i]);
      if (i == 17) begin
        n_cmp++; if (active !== 1'b0) begin n_err++;
          $display("FAIL offset_active_early: active=%b expected 0", active); end
      end
      if (i == 18) begin
        n_cmp++; if (active !== 1'b1) begin n_err++;
          $display("FAIL offset_active_lock: active=%b expected 1", active); end
      end
      if (i == 25) begin
        n_cmp++; if (valid_out !== 1'b0) begin n_err++;
          $display("FAIL offset_valid_early: valid_out=%b expected 0", valid_out); end
      end
      if (i == 26) begin
        n_cmp++; if (data_out !== 8'h3C || valid_out !== 1'b1) begin n_err++;
          $display("FAIL offset_word: data_out=%h valid_out=%b expected 3c/1", data_out, valid_out); end
      end
    end
  endtask

  task automatic test_align_fail();
    logic [31:0] s;
    s = {8'hBC, 8'h00, 8'hBC, 8'hBC};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      send_bit(s[31 - i]);
      if (i == 15) begin
        n_cmp++; if (active !== 1'b0 || word_strobe !== 1'b1) begin n_err++;
          $display("FAIL align_fail_boundary: active=%b word_strobe=%b expected 0/1", active, word_strobe); end
      end
      if (i == 23 || i == 30) begin
        n_cmp++; if (active !== 1'b0) begin n_err++;
          $display("FAIL align_fail_relock_early edge %0d: active=%b expected 0", i + 1, active); end
      end
      if (i == 31) begin
        n_cmp++; if (active !== 1'b1) begin n_err++;
          $display("FAIL align_fail_relock: active=%b expected 1", active); end
      end
    end
  endtask

  task automatic test_idle_vs_data();
    logic [15:0] s;
    s = {8'hBC, 8'hA5};
    do_reset();
    send_word(8'hBC); send_word(8'hBC);
    for (int i = 0; i < 16; i++) begin
      send_bit(s[15 - i]);
      if (i == 7 || i == 11) begin
        n_cmp++; if (data_out !== 8'hBC || valid_out !== 1'b0) begin n_err++;
          $display("FAIL idle_com_word edge %0d: data_out=%h valid_out=%b expected bc/0", i, data_out, valid_out); end
      end
      if (i == 15) begin
        n_cmp++; if (data_out !== 8'hA5 || valid_out !== 1'b1) begin n_err++;
          $display("FAIL idle_data_word: data_out=%h valid_out=%b expected a5/1", data_out, valid_out); end
      end
    end
  endtask

  task automatic test_realign();
    bit exp_a;
    do_reset();
    send_word(8'hBC); send_word(8'hBC); send_word(8'h5A);
    send_bit(1'b0);
    send_word(8'hBC);
    n_cmp++; if (active !== 1'b1) begin n_err++;
      $display("FAIL realign_first_com: active=%b expected 1", active); end
    send_word(8'hBC);
`ifdef SP_REALIGN_EN
    exp_a = 1'b0;
`else
    exp_a = 1'b1;
`endif
    n_cmp++; if (active !== exp_a) begin n_err++;
      $display("FAIL realign_second_com: active=%b expected %b", active, exp_a); end
    n_cmp++; if (data_out !== W'(exp_dat) || valid_out !== exp_vld) begin n_err++;
      $display("FAIL realign_outputs: data_out=%h valid_out=%b expected %h/%b", data_out, valid_out, exp_dat[7:0], exp_vld); end
    send_word(8'hBC);
    for (int j = 7; j >= 0; j--) begin
      send_bit(j[0] ? 1'b0 : 1'b1);
    end
    send_word(8'h00);
    n_cmp++; if (active !== exp_act) begin n_err++;
      $display("FAIL realign_model_mid: active=%b expected %b", active, exp_act); end
  endtask

  task automatic test_random();
    int r;
    logic [W-1:0] w;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int k = 0; k < 120; k++) begin
        r = $urandom_range(0, 9);
        if (r < 5) w = W'(COM);
        else w = W'($urandom_range(0, MASK));
        if (r == 9) begin
          for (int s = 0; s < $urandom_range(1, 3); s++) begin
            send_bit(1'($urandom_range(0, 1)));
            n_cmp++; if (data_out !== W'(exp_dat) || valid_out !== exp_vld || word_strobe !== exp_strb || active !== exp_act) begin n_err++;
              $display("FAIL random_slip r%0d w%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", round, k,
                data_out, valid_out, word_strobe, active, exp_dat[7:0], exp_vld, exp_strb, exp_act); end
          end
        end
        for (int j = W - 1; j >= 0; j--) begin
          send_bit(w[j]);
          n_cmp++; if (data_out !== W'(exp_dat) || valid_out !== exp_vld || word_strobe !== exp_strb || active !== exp_act) begin n_err++;
            $display("FAIL random_bit r%0d w%0d b%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", round, k, j,
              data_out, valid_out, word_strobe, active, exp_dat[7:0], exp_vld, exp_strb, exp_act); end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    data_in = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_lock_basic();
    test_offset_lock();
    test_align_fail();
    test_idle_vs_data();
    test_realign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
